// File: rtl/karatsuba_poly_mult_seq.sv
// rtl/karatsuba_poly_mult_seq.sv - digit-serial carry-less GF(2)[x] multiplier with optional mod-P reduction
module karatsuba_poly_mult_seq #(
  parameter int             N    = 8,
  parameter int             D    = 2,
  parameter logic [N-1:0]   POLY = N'(8'h1B)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic             in_reduce,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-2:0]   out_c,
  output logic             out_reduced
);

  // W: full product width; RW: width of (acc * x^D) before folding back into N bits
  localparam int W  = 2*N-1;
  localparam int RW = N+D;
  localparam int ND = N/D;
  localparam int CW = $clog2(ND+1);
  localparam logic [RW-1:0] P_FULL = RW'({1'b1, POLY});

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic            reduce_q, reduce_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    acc_q, acc_d;

  logic [D-1:0]    digit;
  logic [RW-1:0]   prod;
  logic [W-1:0]    full_next;
  logic [W-1:0]    red_next;

  // Schoolbook N x D carry-less product; result fits in N+D-1 bits
  function automatic logic [RW-1:0] clmul_digit(input logic [N-1:0] a, input logic [D-1:0] dg);
    logic [RW-1:0] r;
    r = '0;
    for (int i = 0; i < D; i++) begin
      if (dg[i]) r = r ^ (RW'(a) << i);
    end
    return r;
  endfunction

  // Fold bits N..N+D-1 back using x^N = POLY, highest bit first
  function automatic logic [N-1:0] reduce_mod_p(input logic [RW-1:0] v);
    logic [RW-1:0] t;
    t = v;
    for (int i = RW-1; i >= N; i--) begin
      if (t[i]) t = t ^ (P_FULL << (i-N));
    end
    return t[N-1:0];
  endfunction

  // Datapath for one digit step; reduction is linear so acc*x^D and A*digit are folded together
  always_comb begin
    digit     = b_q[N-1 -: D];
    prod      = clmul_digit(a_q, digit);
    full_next = (acc_q << D) ^ W'(prod);
    red_next  = W'(reduce_mod_p((RW'(acc_q[N-1:0]) << D) ^ prod));
  end

  // Next-state logic: IDLE accepts, BUSY consumes N/D digits then one settle cycle, DONE holds until taken
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    reduce_d = reduce_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d      = in_a;
          b_d      = in_b;
          reduce_d = in_reduce;
          cnt_d    = '0;
          acc_d    = '0;
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q == CW'(ND)) begin
          state_d = S_DONE;
        end else begin
          acc_d = reduce_q ? red_next : full_next;
          b_d   = b_q << D;
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      reduce_q <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      reduce_q <= reduce_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign out_c       = acc_q;
  assign out_reduced = reduce_q;

endmodule

// File: tb/tb_karatsuba_poly_mult_seq.sv
// tb/tb_karatsuba_poly_mult_seq.sv - directed and randomised checks across several N/D configurations
module tb_karatsuba_poly_mult_seq;

  localparam int NI = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [NI-1:0] in_valid_v, in_reduce_v, out_ready_v;
  logic [NI-1:0] in_ready_v, out_valid_v, out_reduced_v;
  logic [15:0]   in_a_v [NI];
  logic [15:0]   in_b_v [NI];
  logic [14:0]   c0, c1, c2, c3;
  logic [30:0]   c4;
  logic [30:0]   out_c_v [NI];

  assign out_c_v[0] = {16'b0, c0};
  assign out_c_v[1] = {16'b0, c1};
  assign out_c_v[2] = {16'b0, c2};
  assign out_c_v[3] = {16'b0, c3};
  assign out_c_v[4] = c4;

  int          n_tab [NI] = '{8, 8, 8, 8, 16};
  int          d_tab [NI] = '{2, 1, 4, 8, 2};
  logic [15:0] p_tab [NI] = '{16'h001B, 16'h001B, 16'h001B, 16'h001B, 16'h002B};

  int checks = 0;
  int errors = 0;

  karatsuba_poly_mult_seq #(.N(8), .D(2), .POLY(8'h1B)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .in_a(in_a_v[0][7:0]), .in_b(in_b_v[0][7:0]), .in_reduce(in_reduce_v[0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]), .out_c(c0), .out_reduced(out_reduced_v[0]));

  karatsuba_poly_mult_seq #(.N(8), .D(1), .POLY(8'h1B)) dut_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .in_a(in_a_v[1][7:0]), .in_b(in_b_v[1][7:0]), .in_reduce(in_reduce_v[1]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]), .out_c(c1), .out_reduced(out_reduced_v[1]));

  karatsuba_poly_mult_seq #(.N(8), .D(4), .POLY(8'h1B)) dut_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .in_a(in_a_v[2][7:0]), .in_b(in_b_v[2][7:0]), .in_reduce(in_reduce_v[2]),
    .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]), .out_c(c2), .out_reduced(out_reduced_v[2]));

  karatsuba_poly_mult_seq #(.N(8), .D(8), .POLY(8'h1B)) dut_d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[3]), .in_ready(in_ready_v[3]),
    .in_a(in_a_v[3][7:0]), .in_b(in_b_v[3][7:0]), .in_reduce(in_reduce_v[3]),
    .out_valid(out_valid_v[3]), .out_ready(out_ready_v[3]), .out_c(c3), .out_reduced(out_reduced_v[3]));

  karatsuba_poly_mult_seq #(.N(16), .D(2), .POLY(16'h002B)) dut_n16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[4]), .in_ready(in_ready_v[4]),
    .in_a(in_a_v[4]), .in_b(in_b_v[4]), .in_reduce(in_reduce_v[4]),
    .out_valid(out_valid_v[4]), .out_ready(out_ready_v[4]), .out_c(c4), .out_reduced(out_reduced_v[4]));

  // Bit-by-bit schoolbook product followed by long division by x^n + poly
  function automatic logic [30:0] gold(input int n, input logic [15:0] poly,
                                       input logic [15:0] a, input logic [15:0] b, input logic red);
    logic [30:0] p;
    p = '0;
    for (int i = 0; i < n; i++) begin
      if (b[i]) p = p ^ (31'(a) << i);
    end
    if (red) begin
      for (int i = 2*n-2; i >= n; i--) begin
        if (p[i]) begin
          p[i] = 1'b0;
          p = p ^ (31'(poly) << (i-n));
        end
      end
    end
    return p;
  endfunction

  task automatic run_txn(input int k, input logic [15:0] a, input logic [15:0] b, input logic red,
                         input int stall, output logic [30:0] c, output logic r, output int lat);
    int guard;
    @(negedge clk);
    in_a_v[k] = a;
    in_b_v[k] = b;
    in_reduce_v[k] = red;
    in_valid_v[k] = 1'b1;
    guard = 0;
    while (!in_ready_v[k] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (in_ready_v[k] !== 1'b1) begin
      errors++;
      $display("FAIL accept_wait inst %0d in_ready=%b required 1", k, in_ready_v[k]);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid_v[k] = 1'b0;
    in_a_v[k] = 16'($urandom);
    in_b_v[k] = 16'($urandom);
    in_reduce_v[k] = ~red;
    lat = 0;
    while (!out_valid_v[k] && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    repeat (stall) @(negedge clk);
    c = out_c_v[k];
    r = out_reduced_v[k];
    out_ready_v[k] = 1'b1;
    @(negedge clk);
    out_ready_v[k] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid_v = '0;
    in_reduce_v = '0;
    out_ready_v = '0;
    for (int k = 0; k < NI; k++) begin
      in_a_v[k] = '0;
      in_b_v[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (in_ready_v[k] !== 1'b1) begin errors++; $display("FAIL reset_in_ready inst %0d got %b want 1", k, in_ready_v[k]); end
      checks++;
      if (out_valid_v[k] !== 1'b0) begin errors++; $display("FAIL reset_out_valid inst %0d got %b want 0", k, out_valid_v[k]); end
      checks++;
      if (out_c_v[k] !== 31'h0) begin errors++; $display("FAIL reset_out_c inst %0d got %h want 0", k, out_c_v[k]); end
      checks++;
      if (out_reduced_v[k] !== 1'b0) begin errors++; $display("FAIL reset_out_reduced inst %0d got %b want 0", k, out_reduced_v[k]); end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    logic [15:0] ta [6] = '{16'h53, 16'h53, 16'hFF, 16'h00, 16'h00, 16'hA7};
    logic [15:0] tb [6] = '{16'hCA, 16'hCA, 16'hFF, 16'hA7, 16'hA7, 16'h00};
    logic        tr [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [30:0] te [6] = '{31'h3F7E, 31'h0001, 31'h5555, 31'h0, 31'h0, 31'h0};
    logic [30:0] c;
    logic r;
    int lat;
    for (int i = 0; i < 6; i++) begin
      run_txn(0, ta[i], tb[i], tr[i], i % 3, c, r, lat);
      checks++;
      if (c !== te[i]) begin errors++; $display("FAIL vec%0d_out_c got %h want %h", i, c, te[i]); end
      checks++;
      if (r !== tr[i]) begin errors++; $display("FAIL vec%0d_out_reduced got %b want %b", i, r, tr[i]); end
      checks++;
      if (lat != 5) begin errors++; $display("FAIL vec%0d_latency got %0d want 5", i, lat); end
    end
  endtask

  task automatic test_backpressure();
    int guard;
    @(negedge clk);
    in_a_v[0] = 16'h57;
    in_b_v[0] = 16'h83;
    in_reduce_v[0] = 1'b1;
    in_valid_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    guard = 0;
    while (!out_valid_v[0] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid_v[0] !== 1'b1 || out_c_v[0] !== 31'h00C1 || in_ready_v[0] !== 1'b0 || out_reduced_v[0] !== 1'b1)
        begin
          errors++;
          $display("FAIL stall_hold cycle %0d out_valid=%b out_c=%h in_ready=%b out_reduced=%b want 1 000000c1 0 1",
                   i, out_valid_v[0], out_c_v[0], in_ready_v[0], out_reduced_v[0]);
        end
      @(negedge clk);
    end
    out_ready_v[0] = 1'b1;
    @(negedge clk);
    out_ready_v[0] = 1'b0;
    checks++;
    if (in_ready_v[0] !== 1'b1 || out_valid_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL stall_release in_ready=%b out_valid=%b want 1 0", in_ready_v[0], out_valid_v[0]);
    end
  endtask

  task automatic test_abort();
    logic [30:0] c;
    logic r;
    int lat;
    logic seen;
    @(negedge clk);
    in_a_v[0] = 16'h53;
    in_b_v[0] = 16'hCA;
    in_reduce_v[0] = 1'b1;
    in_valid_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid_v[0] !== 1'b0 || in_ready_v[0] !== 1'b1 || out_c_v[0] !== 31'h0 || out_reduced_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs out_valid=%b in_ready=%b out_c=%h out_reduced=%b want 0 1 0 0",
               out_valid_v[0], in_ready_v[0], out_c_v[0], out_reduced_v[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid_v[0] !== 1'b0 || in_ready_v[0] !== 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL abort_no_residue stray activity=%b want 0", seen); end
    run_txn(0, 16'h02, 16'h80, 1'b1, 1, c, r, lat);
    checks++;
    if (c !== 31'h001B) begin errors++; $display("FAIL abort_next_out_c got %h want 0000001b", c); end
    checks++;
    if (r !== 1'b1) begin errors++; $display("FAIL abort_next_reduced got %b want 1", r); end
    checks++;
    if (lat != 5) begin errors++; $display("FAIL abort_next_latency got %0d want 5", lat); end
  endtask

  task automatic test_sweep();
    logic [30:0] c, exp_c;
    logic r, red;
    int lat, exp_lat, stall;
    logic [15:0] a, b, mask;
    for (int k = 0; k < NI; k++) begin
      mask = (n_tab[k] == 16) ? 16'hFFFF : 16'h00FF;
      exp_lat = n_tab[k] / d_tab[k] + 1;
      for (int t = 0; t < 200; t++) begin
        a = 16'($urandom) & mask;
        b = 16'($urandom) & mask;
        if (t == 0) a = 16'h0;
        if (t == 1) b = 16'h0;
        if (t == 2) begin a = mask; b = mask; end
        red = 1'($urandom);
        stall = $urandom_range(0, 3);
        run_txn(k, a, b, red, stall, c, r, lat);
        exp_c = gold(n_tab[k], p_tab[k], a, b, red);
        checks++;
        if (c !== exp_c) begin
          errors++;
          $display("FAIL sweep_out_c inst %0d a=%h b=%h red=%b got %h want %h", k, a, b, red, c, exp_c);
        end
        checks++;
        if (r !== red) begin errors++; $display("FAIL sweep_reduced inst %0d got %b want %b", k, r, red); end
        checks++;
        if (lat != exp_lat) begin errors++; $display("FAIL sweep_latency inst %0d got %0d want %0d", k, lat, exp_lat); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_abort();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
